// File: rtl/dcpu_membus_if.sv
// dcpu_membus bus bundle: core access port plus external I/O req/ack port.
// Signal names keep the membus point of view (i_ = into membus).
interface dcpu_membus_if;
    logic        i_cs;
    logic        i_we;
    logic [15:0] i_addr;
    logic [15:0] i_dat;
    logic [15:0] o_dat;
    logic        o_ack;
    logic        o_io_cs;
    logic        o_io_we;
    logic [7:0]  o_io_addr;
    logic [15:0] o_io_dat;
    logic [15:0] i_io_dat;
    logic        i_io_ack;

    modport slave (
        input  i_cs, i_we, i_addr, i_dat, i_io_dat, i_io_ack,
        output o_dat, o_ack, o_io_cs, o_io_we, o_io_addr, o_io_dat
    );

    modport master (
        output i_cs, i_we, i_addr, i_dat, i_io_dat, i_io_ack,
        input  o_dat, o_ack, o_io_cs, o_io_we, o_io_addr, o_io_dat
    );
endinterface

// File: rtl/dcpu_membus.sv
// dcpu bus slave: internal RAM, req/ack I/O window, unmapped space.
// Optional I/O watchdog with sticky bus error: DCPU_MEMBUS_TIMEOUT_EN.
module dcpu_membus #(
    parameter int          RAM_AW  = 12,
    parameter logic [15:0] IO_BASE = 16'hFF00,
    parameter int          TIMEOUT = 15
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    dcpu_membus_if.slave  bus,
    output logic          o_buserr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAM,
        S_IO,
        S_ACK
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_ack;
    logic [15:0]       r_dat;
    logic              r_io_cs;
    logic              r_io_we;
    logic [7:0]        r_io_addr;
    logic [15:0]       r_io_dat;
    logic [15:0]       r_rdata;
    logic [15:0]       r_mem [2**RAM_AW];

    logic              w_ack;
    logic [15:0]       w_dat;
    logic              w_io_cs;
    logic              w_io_we;
    logic [7:0]        w_io_addr;
    logic [15:0]       w_io_dat;

    logic              w_req;
    logic              w_ram_hit;
    logic              w_io_hit;
    logic              w_ram_wr;
    logic              w_ram_rd;
    logic              w_io_start;
    logic              w_tmo;
    logic [RAM_AW-1:0] w_ram_addr;

    // The ack cycle is never a new request, even with i_cs still held.
    assign w_req      = bus.i_cs && !r_ack && (r_state == S_IDLE);
    assign w_ram_hit  = ({16'd0, bus.i_addr} < (32'd1 << RAM_AW));
    assign w_io_hit   = !w_ram_hit && (bus.i_addr >= IO_BASE);
    assign w_ram_addr = bus.i_addr[RAM_AW-1:0];
    assign w_ram_wr   = w_req && w_ram_hit && bus.i_we;
    assign w_ram_rd   = w_req && w_ram_hit && !bus.i_we;
    assign w_io_start = w_req && w_io_hit;

`ifdef DCPU_MEMBUS_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tcnt;
    logic          r_err;

    assign w_tmo = (r_state == S_IO) && !bus.i_io_ack &&
                   (r_tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_io_start)
                r_tcnt <= '0;
            else if (r_state == S_IO && !bus.i_io_ack)
                r_tcnt <= r_tcnt + 1'b1;
            if (w_tmo)
                r_err <= 1'b1;
        end
    end

    assign o_buserr = r_err;
`else
    assign w_tmo    = 1'b0;
    assign o_buserr = 1'b0;
`endif

    // RAM is not reset; reads are registered for the RAM state.
    always_ff @(posedge i_clk) begin
        if (w_ram_wr)
            r_mem[w_ram_addr] <= bus.i_dat;
        if (w_ram_rd)
            r_rdata <= r_mem[w_ram_addr];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    unique case (1'b1)
                        w_ram_hit: w_next = bus.i_we ? S_ACK : S_RAM;
                        w_io_hit:  w_next = S_IO;
                        default:   w_next = S_ACK;
                    endcase
                end
            end
            S_RAM:   w_next = S_IDLE;
            S_ACK:   w_next = S_IDLE;
            S_IO: begin
                if (bus.i_io_ack || w_tmo)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ack     = 1'b0;
        w_dat     = 16'h0000;
        w_io_cs   = r_io_cs;
        w_io_we   = r_io_we;
        w_io_addr = r_io_addr;
        w_io_dat  = r_io_dat;
        unique case (r_state)
            S_IDLE: begin
                if (w_io_start) begin
                    w_io_cs   = 1'b1;
                    w_io_we   = bus.i_we;
                    w_io_addr = bus.i_addr[7:0];
                    w_io_dat  = bus.i_dat;
                end
            end
            S_RAM: begin
                w_ack = 1'b1;
                w_dat = r_rdata;
            end
            S_ACK: w_ack = 1'b1;
            S_IO: begin
                if (bus.i_io_ack) begin
                    w_io_cs = 1'b0;
                    w_ack   = 1'b1;
                    w_dat   = r_io_we ? 16'h0000 : bus.i_io_dat;
                end else if (w_tmo) begin
                    w_io_cs = 1'b0;
                    w_ack   = 1'b1;
                    w_dat   = 16'hFFFF;
                end
            end
            default: w_ack = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ack     <= 1'b0;
            r_dat     <= 16'h0000;
            r_io_cs   <= 1'b0;
            r_io_we   <= 1'b0;
            r_io_addr <= 8'h00;
            r_io_dat  <= 16'h0000;
        end else begin
            r_ack     <= w_ack;
            r_dat     <= w_dat;
            r_io_cs   <= w_io_cs;
            r_io_we   <= w_io_we;
            r_io_addr <= w_io_addr;
            r_io_dat  <= w_io_dat;
        end
    end

    assign bus.o_ack     = r_ack;
    assign bus.o_dat     = r_dat;
    assign bus.o_io_cs   = r_io_cs;
    assign bus.o_io_we   = r_io_we;
    assign bus.o_io_addr = r_io_addr;
    assign bus.o_io_dat  = r_io_dat;

endmodule

// File: doc/dcpu_membus.md
Name: dcpu_membus

Overview:
- Memory/bus slave sitting directly downstream of the dcpu core's single bus master port.
- Decodes each core access (i_cs/i_we/i_addr) into one of three regions:
  - internal synchronous RAM,
  - an external memory-mapped I/O port with a req/ack handshake,
  - unmapped space.
- Returns read data and a single-cycle o_ack that the core uses to advance its FETCH/EXECUTE state machine.

Parameters:
- RAM_AW, 12, RAM address width; RAM occupies word addresses 0 .. 2^RAM_AW-1.
- IO_BASE, 16'hFF00, first I/O address; I/O region is IO_BASE..16'hFFFF; o_io_addr is the low 8 bits.
- TIMEOUT, 15, cycles to wait for i_io_ack before forcing completion (only with the optional feature); 4-bit counter minimum.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_cs  in  1  core access request; held high until o_ack
- i_we  in  1  core write strobe; valid with i_cs
- i_addr  in  16  core word address
- i_dat  in  16  core write data
- o_dat  out  16  read data; valid only in the o_ack cycle
- o_ack  out  1  single-cycle completion pulse
- o_io_cs  out  1  I/O request; held until i_io_ack or timeout
- o_io_we  out  1  I/O write strobe
- o_io_addr  out  8  I/O register address
- o_io_dat  out  16  I/O write data
- i_io_dat  in  16  I/O read data; sampled on i_io_ack
- i_io_ack  in  1  I/O completion
- o_buserr  out  1  sticky error flag; cleared only by reset

Behaviour:
- FSM states: IDLE, RAM, IO, ACK. All outputs are registered.
- Reset values: state IDLE; o_ack 0; o_dat 0; o_io_cs/o_io_we 0; o_io_addr/o_io_dat 0; o_buserr 0; timeout counter 0. RAM contents are not reset.
- IDLE, i_cs=0: stay in IDLE.
- IDLE, i_cs=1: decode i_addr.
  - RAM hit (i_addr < 2^RAM_AW):
    - Write: RAM written at the clock edge; go to ACK.
    - Read: RAM read registered; go to RAM.
  - I/O hit (i_addr >= IO_BASE):
    - Latch o_io_addr = i_addr[7:0], o_io_we = i_we, o_io_dat = i_dat.
    - Set o_io_cs=1; go to IO.
  - Unmapped:
    - Writes are dropped; reads return 16'h0000.
    - Go to ACK. o_buserr is not set.
- RAM: present RAM data on o_dat, pulse o_ack; go to IDLE.
  - Read latency: i_cs seen at edge N, o_ack high in cycle N+2.
- ACK: pulse o_ack (o_dat = 0 for writes/unmapped); go to IDLE.
  - Write latency: o_ack high in cycle N+2.
- IO: on i_io_ack=1:
  - o_io_cs <= 0; o_dat <= i_io_dat (write: 0); pulse o_ack; go to IDLE.
  - Minimum latency 3 cycles.
- After any o_ack the block returns to IDLE, and the next access is sampled at the following edge.
  - The core's i_cs may stay high across its FETCH to EXECUTE transition; the cycle in which o_ack is high is never treated as a new request.
- i_addr/i_we/i_dat are sampled only in IDLE; changes during RAM/IO/ACK are ignored.
- i_io_ack while not in IO is ignored.
- Reset asserted mid-access:
  - o_io_cs and o_ack drop immediately (asynchronously); the access is aborted.
  - An in-progress RAM write is guaranteed only if its edge precedes the reset.
- Address boundaries:
  - 2^RAM_AW-1 is RAM; 2^RAM_AW is unmapped.
  - IO_BASE-1 is unmapped unless inside RAM.
  - 16'hFFFF is I/O address 8'hFF.

Optional Feature:
- Macro: DCPU_MEMBUS_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to IO and increments each IO cycle without i_io_ack.
  - On reaching TIMEOUT: o_io_cs <= 0, o_dat <= 16'hFFFF, pulse o_ack, set o_buserr; go to IDLE.
  - i_io_ack in the same cycle as timeout wins: normal completion, no error.
- Undefined:
  - No counter; IO waits indefinitely.
  - o_buserr is tied to 0.

Test Plan:
- Reset, then read from 0x0005 after a prior write of 0x1234 -> o_ack exactly 2 cycles after i_cs, one cycle wide, o_dat=0x1234.
- Back-to-back core-style accesses with i_cs held high (fetch 0x0000, then execute read 0x0FFF) -> two distinct o_ack pulses; no extra access from the held i_cs.
- Write 0xBEEF to 0xFF10; peripheral acks after 4 cycles -> o_io_cs high 4 cycles, o_io_addr=0x10, o_io_we=1, o_io_dat=0xBEEF; o_ack on the cycle after i_io_ack.
- Read 0x2000 (unmapped, RAM_AW=12) -> o_dat=0x0000, o_ack at N+2, o_buserr stays 0; then write 0x2000 and read 0x0000 -> RAM unchanged.
- With DCPU_MEMBUS_TIMEOUT_EN: read 0xFF00 and never ack -> o_ack after TIMEOUT=15 IO cycles, o_dat=0xFFFF, o_buserr=1 sticky until reset.
- Assert i_reset_n=0 during an IO wait -> o_io_cs and o_ack low immediately; after release, state is IDLE and a RAM read completes normally.
